// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states and
// lane helpers used by both the top level and the load aligner.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Low address bits that actually select a lane; bits a size cannot use are masked off.
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return addr_lo;
      SZ_HALF: return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 4'b0001 << offset;
      SZ_HALF: return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: picks the addressed lane out of a bus word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = load_word[7:0];
    half_lane = offset[1] ? load_word[31:16] : load_word[15:0];
    result    = load_word;
    case (offset)
      2'd1:    byte_lane = load_word[15:8];
      2'd2:    byte_lane = load_word[23:16];
      2'd3:    byte_lane = load_word[31:24];
      default: byte_lane = load_word[7:0];
    endcase
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      default: result = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one bus access per instruction and stalls the pipeline until done.
// Optional MISALIGN_EXC_EN raises misalign_exc instead of masking misaligned address bits.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_op,
  input  logic              ex_mem_we,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic [31:0]       ex_mem_addr,
  input  logic [31:0]       ex_mem_wdata,
  output logic              stallreq,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
`ifdef MISALIGN_EXC_EN
  output logic              misalign_exc,
`endif
  mem_access_unit_if.master bus
);

  state_t      state, next_state;
  logic [1:0]  op_size;
  logic [1:0]  op_offset;
  logic        op_unsigned;
  logic        op_we;
  logic        issue_misaligned;
  logic [31:0] load_result;

`ifdef MISALIGN_EXC_EN
  logic        mis_q;
  assign issue_misaligned = is_misaligned(ex_mem_size, ex_mem_addr[1:0]);
`else
  assign issue_misaligned = 1'b0;
`endif

  load_align u_load_align (
    .load_word   (bus.bus_rdata),
    .offset      (op_offset),
    .size        (op_size),
    .is_unsigned (op_unsigned),
    .result      (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // DONE always falls back to IDLE so a still-asserted ex_mem_op is not reissued.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (ex_mem_op) next_state = issue_misaligned ? ST_DONE : ST_BUSY;
      ST_BUSY: if (bus.bus_ack) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    stallreq    = ((state == ST_IDLE) && ex_mem_op) || (state == ST_BUSY);
    rdata_valid = (state == ST_DONE);
`ifdef MISALIGN_EXC_EN
    misalign_exc = (state == ST_DONE) && mis_q;
`endif
  end

  // Bus outputs are registered at issue and held untouched until the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      rdata         <= '0;
      op_size       <= SZ_BYTE;
      op_offset     <= 2'b00;
      op_unsigned   <= 1'b0;
      op_we         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ex_mem_op) begin
            op_size     <= ex_mem_size;
            op_offset   <= eff_offset(ex_mem_size, ex_mem_addr[1:0]);
            op_unsigned <= ex_mem_unsigned;
            op_we       <= ex_mem_we;
            if (issue_misaligned) begin
              rdata <= '0;
            end else begin
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= ex_mem_we;
              bus.bus_addr  <= {ex_mem_addr[31:2], 2'b00};
              bus.bus_be    <= byte_enables(ex_mem_size, eff_offset(ex_mem_size, ex_mem_addr[1:0]));
              bus.bus_wdata <= store_lanes(ex_mem_size, ex_mem_wdata);
            end
          end
        end
        ST_BUSY: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            rdata       <= op_we ? 32'h0 : load_result;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (rst)                                      mis_q <= 1'b0;
    else if ((state == ST_IDLE) && ex_mem_op)     mis_q <= issue_misaligned;
    else if (state == ST_DONE)                    mis_q <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: loads, stores, lane selection, reset abort
// and misaligned handling in whichever MISALIGN_EXC_EN build is compiled.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_op;
  logic        ex_mem_we;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_unsigned;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_wdata;
  logic        stallreq;
  logic [31:0] rdata;
  logic        rdata_valid;
`ifdef MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  int vecCount = 0;
  int errCount = 0;
  int txCount  = 0;
  int expTx    = 0;
  logic        prevReq = 1'b0;
  logic        seenReq;
  logic        seenWe;
  logic [31:0] seenAddr;
  logic [3:0]  seenBe;
  logic [31:0] seenWdata;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ex_mem_op       (ex_mem_op),
    .ex_mem_we       (ex_mem_we),
    .ex_mem_size     (ex_mem_size),
    .ex_mem_unsigned (ex_mem_unsigned),
    .ex_mem_addr     (ex_mem_addr),
    .ex_mem_wdata    (ex_mem_wdata),
    .stallreq        (stallreq),
    .rdata           (rdata),
    .rdata_valid     (rdata_valid),
`ifdef MISALIGN_EXC_EN
    .misalign_exc    (misalign_exc),
`endif
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  // Counts bus transactions as rising edges of bus_req.
  always @(posedge clk) begin
    prevReq <= bus.bus_req;
    if (bus.bus_req && !prevReq) txCount <= txCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic op, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ack, input logic [31:0] brdata);
    @(posedge clk);
    #1;
    ex_mem_op       = op;
    ex_mem_we       = we;
    ex_mem_size     = size;
    ex_mem_unsigned = uns;
    ex_mem_addr     = addr;
    ex_mem_wdata    = wdata;
    bus.bus_ack     = ack;
    bus.bus_rdata   = brdata;
    #1;
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput(tag, {31'd0, rdata_valid}, 32'd0);
  endtask

  // Minimum-latency access: issue, BUSY with ack, then DONE with ex_mem_op still held.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] brdata);
    applyStimulus(1'b1, we, size, uns, addr, wdata, 1'b0, 32'h0);
    applyStimulus(1'b1, we, size, uns, addr, wdata, 1'b1, brdata);
    seenReq   = bus.bus_req;
    seenWe    = bus.bus_we;
    seenAddr  = bus.bus_addr;
    seenBe    = bus.bus_be;
    seenWdata = bus.bus_wdata;
    applyStimulus(1'b1, we, size, uns, addr, wdata, 1'b0, 32'h0);
    expTx++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_bus_req",   {31'd0, bus.bus_req}, 32'd0);
    checkOutput("rst_bus_we",    {31'd0, bus.bus_we},  32'd0);
    checkOutput("rst_bus_be",    {28'd0, bus.bus_be},  32'd0);
    checkOutput("rst_bus_addr",  bus.bus_addr,         32'd0);
    checkOutput("rst_bus_wdata", bus.bus_wdata,        32'd0);
    checkOutput("rst_rdata",     rdata,                32'd0);
    checkOutput("rst_valid",     {31'd0, rdata_valid}, 32'd0);
    checkOutput("rst_stall",     {31'd0, stallreq},    32'd0);
`ifdef MISALIGN_EXC_EN
    checkOutput("rst_misalign",  {31'd0, misalign_exc}, 32'd0);
`endif
    rst = 1'b0;

    // Word load with one wait cycle, ex_mem_op held through DONE.
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ldw_issue_stall", {31'd0, stallreq},    32'd1);
    checkOutput("ldw_issue_req",   {31'd0, bus.bus_req}, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ldw_busy1_req",   {31'd0, bus.bus_req}, 32'd1);
    checkOutput("ldw_busy1_addr",  bus.bus_addr,         32'h100);
    checkOutput("ldw_busy1_be",    {28'd0, bus.bus_be},  32'hF);
    checkOutput("ldw_busy1_we",    {31'd0, bus.bus_we},  32'd0);
    checkOutput("ldw_busy1_stall", {31'd0, stallreq},    32'd1);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    checkOutput("ldw_busy2_stall", {31'd0, stallreq},    32'd1);
    checkOutput("ldw_busy2_addr",  bus.bus_addr,         32'h100);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ldw_done_stall",  {31'd0, stallreq},    32'd0);
    checkOutput("ldw_done_valid",  {31'd0, rdata_valid}, 32'd1);
    checkOutput("ldw_done_rdata",  rdata,                32'hDEADBEEF);
    checkOutput("ldw_done_req",    {31'd0, bus.bus_req}, 32'd0);
    expTx++;
    idleCycle("ldw_after_valid");
    checkOutput("ldw_after_rdata_hold", rdata,                32'hDEADBEEF);
    checkOutput("ldw_after_stall",      {31'd0, stallreq},    32'd0);
    idleCycle("ldw_idle2_valid");
    checkOutput("single_issue_txcount", txCount,              expTx);
    checkOutput("single_issue_req",     {31'd0, bus.bus_req}, 32'd0);

    // Stray ack while idle must change nothing.
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'h55555555);
    idleCycle("idle_ack_valid");
    checkOutput("idle_ack_rdata", rdata, 32'hDEADBEEF);

    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF);
    checkOutput("lbs_be",    {28'd0, seenBe},      32'h8);
    checkOutput("lbs_addr",  seenAddr,             32'h100);
    checkOutput("lbs_rdata", rdata,                32'hFFFFFF80);
    checkOutput("lbs_valid", {31'd0, rdata_valid}, 32'd1);
    idleCycle("lbs_after_valid");

    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF);
    checkOutput("lbu_rdata", rdata, 32'h00000080);
    idleCycle("lbu_after_valid");

    access(1'b1, 2'b01, 1'b0, 32'h202, 32'h00001234, 32'hFFFFFFFF);
    checkOutput("sh_addr",  seenAddr,             32'h200);
    checkOutput("sh_be",    {28'd0, seenBe},      32'hC);
    checkOutput("sh_wdata", seenWdata,            32'h12341234);
    checkOutput("sh_we",    {31'd0, seenWe},      32'd1);
    checkOutput("sh_req",   {31'd0, seenReq},     32'd1);
    checkOutput("sh_valid", {31'd0, rdata_valid}, 32'd1);
    checkOutput("sh_rdata", rdata,                32'h0);
    idleCycle("sh_after_valid");

    access(1'b1, 2'b00, 1'b0, 32'h001, 32'h123456AB, 32'h0);
    checkOutput("sb_be",    {28'd0, seenBe}, 32'h2);
    checkOutput("sb_wdata", seenWdata,       32'hABABABAB);
    idleCycle("sb_after_valid");

    access(1'b0, 2'b01, 1'b0, 32'h002, 32'h0, 32'h80011234);
    checkOutput("lh_hi_be",    {28'd0, seenBe}, 32'hC);
    checkOutput("lh_hi_rdata", rdata,           32'hFFFF8001);
    idleCycle("lh_hi_after_valid");

    access(1'b0, 2'b01, 1'b0, 32'h000, 32'h0, 32'h1234F00D);
    checkOutput("lh_lo_be",    {28'd0, seenBe}, 32'h3);
    checkOutput("lh_lo_rdata", rdata,           32'hFFFFF00D);
    idleCycle("lh_lo_after_valid");

`ifdef MISALIGN_EXC_EN
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0);
    checkOutput("mis_issue_stall", {31'd0, stallreq},     32'd1);
    checkOutput("mis_issue_req",   {31'd0, bus.bus_req},  32'd0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0);
    checkOutput("mis_done_exc",    {31'd0, misalign_exc}, 32'd1);
    checkOutput("mis_done_valid",  {31'd0, rdata_valid},  32'd1);
    checkOutput("mis_done_rdata",  rdata,                 32'h0);
    checkOutput("mis_done_req",    {31'd0, bus.bus_req},  32'd0);
    idleCycle("mis_after_valid");
    checkOutput("mis_after_exc",   {31'd0, misalign_exc}, 32'd0);
    checkOutput("mis_txcount",     txCount,               expTx);
`else
    access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h11223344);
    checkOutput("mask_w_addr",  seenAddr,        32'h100);
    checkOutput("mask_w_be",    {28'd0, seenBe}, 32'hF);
    checkOutput("mask_w_rdata", rdata,           32'h11223344);
    idleCycle("mask_w_after_valid");
    access(1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 32'hBEEF0000);
    checkOutput("mask_h_be",    {28'd0, seenBe}, 32'hC);
    checkOutput("mask_h_rdata", rdata,           32'h0000BEEF);
    idleCycle("mask_h_after_valid");
`endif

    // Reset on the second BUSY cycle; the ack that follows must be ignored.
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    checkOutput("rbusy_busy1_req", {31'd0, bus.bus_req}, 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    checkOutput("rbusy_busy2_stall", {31'd0, stallreq}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFEF00D);
    rst = 1'b0;
    checkOutput("rbusy_req_dropped", {31'd0, bus.bus_req}, 32'd0);
    checkOutput("rbusy_stall",       {31'd0, stallreq},    32'd0);
    checkOutput("rbusy_valid",       {31'd0, rdata_valid}, 32'd0);
    expTx++;
    idleCycle("rbusy_ack_ignored_valid");
    checkOutput("rbusy_rdata",   rdata,                32'h0);
    checkOutput("rbusy_req",     {31'd0, bus.bus_req}, 32'd0);
    checkOutput("final_txcount", txCount,              expTx);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock; rst  in  1  reset rst, synchronous, active-high.
REQ-002 SHALL: ex_mem_op  in  1  EX stage holds a load/store this cycle; ex_mem_we  in  1  1=store, 0=load.
REQ-003 SHALL: ex_mem_size  in  2  00=byte, 01=half, 10=word, 11 reserved and treated as word; ex_mem_unsigned  in  1  zero-extend load.
REQ-004 SHALL: ex_mem_addr  in  32  byte address; ex_mem_wdata  in  32  store data, right-justified.
REQ-005 SHALL: stallreq  out  1  active-high stall request to the pipeline controller.
REQ-006 SHALL: rdata  out  32  aligned, extended load result; rdata_valid  out  1  one-cycle result strobe.
REQ-007 SHALL: bus_req  out  1; bus_we  out  1; bus_addr  out  32, word-aligned; bus_be  out  4; bus_wdata  out  32.
REQ-008 SHALL: bus_ack  in  1  single-cycle completion; bus_rdata  in  32  valid only while bus_ack=1.
REQ-009 SHALL: misalign_exc  out  1  one-cycle exception strobe; present only when MISALIGN_EXC_EN is defined.

Function
REQ-010 SHALL: FSM states IDLE, BUSY, DONE.
REQ-011 SHALL: IDLE with ex_mem_op=1 -> latch op, drive bus outputs, go BUSY; with ex_mem_op=0 -> stay IDLE.
REQ-012 SHALL: BUSY holds bus_req=1 and keeps bus_addr, bus_be, bus_wdata and bus_we stable until bus_ack=1.
REQ-013 SHALL: BUSY with bus_ack=1 -> capture bus_rdata for loads, drop bus_req on the next edge, go DONE.
REQ-014 SHALL: DONE lasts exactly one cycle with rdata_valid=1, then returns to IDLE; ex_mem_op is ignored in DONE, so the held instruction is never reissued.
REQ-015 SHALL: stallreq is combinational: 1 when (IDLE and ex_mem_op) or BUSY, and 0 in DONE.
REQ-016 SHALL: minimum latency is 3 cycles (issue, ack, DONE); each extra wait cycle before bus_ack adds one cycle.
REQ-017 SHALL: bus_ack is ignored in IDLE and DONE.
REQ-018 SHALL: byte enables are: byte -> 0001 shifted left by addr[1:0]; half -> 0011 shifted left by {addr[1],0}; word -> 1111.
REQ-019 SHALL: store data is replicated across lanes: byte into all 4 lanes, half into both halves.
REQ-020 SHALL: for loads, rdata is the selected lane extended to 32 bits: sign-extended unless ex_mem_unsigned=1; for stores, rdata=0.
REQ-021 SHALL: rdata holds its value outside DONE; rdata_valid is 0 outside DONE.

Reset
REQ-022 SHALL: on rst, state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, rdata_valid=0, misalign_exc=0.
REQ-023 SHALL: rst during BUSY abandons the access; bus_req=0 from the next cycle, and any later bus_ack is ignored.

Configuration
REQ-024 SHALL: macro MISALIGN_EXC_EN defined -> a half access with addr[0]=1 or a word access with addr[1:0]!=0 issues no bus request and goes IDLE->DONE directly, with misalign_exc=1, rdata_valid=1 and rdata=0 in DONE.
REQ-025 SHALL: MISALIGN_EXC_EN undefined -> no misalign_exc port; misaligned low address bits are masked (half: addr[0]; word: addr[1:0]) and the access proceeds normally.

Structure
REQ-026 SHALL: the shared defines package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encodings.
REQ-027 SHALL: sub-module load_align is combinational; inputs are the word, the offset, the size and the unsigned flag; output is the extended result.

Verification
REQ-028 SHALL: load word, addr 0x100, bus_ack on 2nd BUSY cycle, bus_rdata 0xDEADBEEF -> bus_be=1111, stallreq high 3 cycles, rdata=0xDEADBEEF in DONE (4 cycles total).
REQ-029 SHALL: signed load byte, addr 0x103, bus_rdata 0x80FFFFFF -> bus_be=1000, rdata=0xFFFFFF80; the same load with ex_mem_unsigned=1 -> rdata=0x00000080.
REQ-030 SHALL: store half 0x1234, addr 0x202 -> bus_addr=0x200, bus_be=1100, bus_wdata=0x12341234, bus_we=1, rdata_valid for one cycle.
REQ-031 SHALL: ex_mem_op held through DONE, then deasserted -> exactly one bus_req transaction; no second issue.
REQ-032 SHALL: rst asserted on the 2nd BUSY cycle, with bus_ack arriving 1 cycle later -> bus_req=0 and state IDLE, no rdata_valid, and the ack is ignored.
REQ-033 SHALL: word load at 0x101 -> with MISALIGN_EXC_EN: no bus_req, misalign_exc=1 in cycle 2; without MISALIGN_EXC_EN: bus_addr=0x100, bus_be=1111.
